// File: rtl/dma_pkg.sv
// Shared definitions for the DMA descriptor queue: FSM encoding,
// descriptor width helper and status counter width.
package dma_pkg;

    // Width of the completed-transfer counter.
    localparam int DONE_W = 16;

    // Issue sequencer states.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    // A descriptor is {src, dest, len}, each addr_w bits wide.
    function automatic int desc_width(input int addr_w);
        return 3 * addr_w;
    endfunction

endpackage

// File: rtl/dma_desc_fifo.sv
// Synchronous descriptor FIFO. Flush clears the queue and takes priority
// over a push in the same cycle; push is ignored when full and pop is
// ignored when empty, so the count can neither overflow nor underflow.
module dma_desc_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 96,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [W-1:0]     wdata_i,
    output logic [W-1:0]     rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign rdata_o = mem_q[rd_q];

    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    // Pointer and occupancy next-state; pointers wrap naturally.
    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + PTR_W'(1);
            if (do_pop)  rd_d = rd_q + PTR_W'(1);
            cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= wdata_i;
    end

endmodule

// File: rtl/dma_cmd_queue.sv
// Descriptor queue and issue sequencer feeding the DMA controller.
// Handshake: a descriptor transfers on any rising edge where cmd_valid and
// cmd_ready are both high; cmd_ready depends only on registered occupancy.
// Bad lengths (zero or not word-multiple) are accepted and dropped.
module dma_cmd_queue
    import dma_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [ADDR_W-1:0]      cmd_src,
    input  logic [ADDR_W-1:0]      cmd_dest,
    input  logic [ADDR_W-1:0]      cmd_len,
    input  logic                   flush,
    input  logic                   err_clear,
    output logic                   start_transfer,
    output logic [ADDR_W-1:0]      src_addr,
    output logic [ADDR_W-1:0]      dest_addr,
    output logic [ADDR_W-1:0]      transfer_length,
    input  logic                   dma_busy,
    output logic [$clog2(DEPTH):0] q_count,
    output logic [DONE_W-1:0]      done_count,
    output logic                   irq_done,
    output logic                   err_len,
    output logic                   err_timeout,
    output logic                   queue_busy,
    output state_t                 dbg_state
);

    localparam int DESC_W = desc_width(ADDR_W);
    localparam int TO_W   = $clog2(TIMEOUT + 1);

    state_t             state_q, state_d;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d, to_inc;
    logic [ADDR_W-1:0]  src_q, src_d, dest_q, dest_d, len_q, len_d;
    logic [DONE_W-1:0]  done_cnt_q, done_cnt_d;
    logic               err_len_q, err_len_d;
    logic               err_to_q, err_to_d;
    logic               irq_q, irq_d;

    logic               len_ok, accept, fifo_push, bad_len_evt;
    logic               fifo_pop, fifo_full, fifo_empty;
    logic               load_en, timeout_evt, done_evt;
    logic [DESC_W-1:0]  fifo_wdata, fifo_rdata;
    logic [ADDR_W-1:0]  head_src, head_dest, head_len;

    assign len_ok      = (cmd_len != '0) && (cmd_len[1:0] == 2'b00);
    assign accept      = cmd_valid && cmd_ready;
    assign fifo_push   = accept && len_ok && !flush;
    assign bad_len_evt = accept && !len_ok && !flush;
    assign fifo_wdata  = {cmd_src, cmd_dest, cmd_len};
    assign {head_src, head_dest, head_len} = fifo_rdata;
    assign to_inc      = to_cnt_q + TO_W'(1);

    dma_desc_fifo #(
        .DEPTH (DEPTH),
        .W     (DESC_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .flush_i (flush),
        .wdata_i (fifo_wdata),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (q_count)
    );

    // Issue sequencer: next state, pop/load strobes and timeout counting.
    always_comb begin
        state_d     = state_q;
        to_cnt_d    = to_cnt_q;
        fifo_pop    = 1'b0;
        load_en     = 1'b0;
        timeout_evt = 1'b0;
        done_evt    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty && !dma_busy && !flush) begin
                    fifo_pop = 1'b1;
                    load_en  = 1'b1;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                to_cnt_d = '0;
                state_d  = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (dma_busy) begin
                    state_d = WAIT_DONE;
                end else begin
                    to_cnt_d = to_inc;
                    if (to_inc == TO_W'(TIMEOUT)) begin
                        timeout_evt = 1'b1;
                        state_d     = IDLE;
                    end
                end
            end
            WAIT_DONE: begin
                if (!dma_busy) begin
                    done_evt = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output descriptor hold, sticky errors (set beats clear) and completion status.
    always_comb begin
        src_d      = load_en ? head_src  : src_q;
        dest_d     = load_en ? head_dest : dest_q;
        len_d      = load_en ? head_len  : len_q;
        err_len_d  = err_clear ? 1'b0 : err_len_q;
        err_to_d   = err_clear ? 1'b0 : err_to_q;
        irq_d      = done_evt;
        done_cnt_d = done_evt ? done_cnt_q + DONE_W'(1) : done_cnt_q;
        if (bad_len_evt) err_len_d = 1'b1;
        if (timeout_evt) err_to_d  = 1'b1;
    end

    // State and status registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            to_cnt_q   <= '0;
            src_q      <= '0;
            dest_q     <= '0;
            len_q      <= '0;
            done_cnt_q <= '0;
            err_len_q  <= 1'b0;
            err_to_q   <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            to_cnt_q   <= to_cnt_d;
            src_q      <= src_d;
            dest_q     <= dest_d;
            len_q      <= len_d;
            done_cnt_q <= done_cnt_d;
            err_len_q  <= err_len_d;
            err_to_q   <= err_to_d;
            irq_q      <= irq_d;
        end
    end

    assign cmd_ready       = !fifo_full;
    assign start_transfer  = (state_q == ISSUE);
    assign src_addr        = src_q;
    assign dest_addr       = dest_q;
    assign transfer_length = len_q;
    assign done_count      = done_cnt_q;
    assign irq_done        = irq_q;
    assign err_len         = err_len_q;
    assign err_timeout     = err_to_q;
    assign queue_busy      = (state_q != IDLE) || (q_count != '0);
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_dma_cmd_queue.sv
// Directed bench for dma_cmd_queue with a small behavioural DMA model.
module tb_dma_cmd_queue;
  import dma_pkg::*;

  localparam int DEPTH   = 4;
  localparam int ADDR_W  = 32;
  localparam int TIMEOUT = 16;
  localparam int WORK    = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_src = '0;
  logic [ADDR_W-1:0] cmd_dest = '0;
  logic [ADDR_W-1:0] cmd_len = '0;
  logic              flush = 1'b0;
  logic              err_clear = 1'b0;
  logic              start_transfer;
  logic [ADDR_W-1:0] src_addr, dest_addr, transfer_length;
  logic              dma_busy;
  logic [2:0]        q_count;
  logic [15:0]       done_count;
  logic              irq_done, err_len, err_timeout, queue_busy;
  state_t            dbg_state;

  int checks = 0;
  int errors = 0;
  logic [ADDR_W-1:0] exp_q[$];
  logic [15:0] exp_done = '0;

  // ---------------- behavioural DMA ----------------
  logic ignore_start = 1'b0;
  logic hold_busy = 1'b0;
  logic model_busy;
  int   work;
  assign dma_busy = model_busy | hold_busy;

  always @(posedge clk) begin
    if (reset) begin
      model_busy <= 1'b0;
      work <= 0;
    end else if (start_transfer && !ignore_start) begin
      model_busy <= 1'b1;
      work <= WORK;
    end else if (work != 0) begin
      work <= work - 1;
      if (work == 1) model_busy <= 1'b0;
    end
  end

  dma_cmd_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_src(cmd_src), .cmd_dest(cmd_dest), .cmd_len(cmd_len),
    .flush(flush), .err_clear(err_clear),
    .start_transfer(start_transfer), .src_addr(src_addr),
    .dest_addr(dest_addr), .transfer_length(transfer_length),
    .dma_busy(dma_busy), .q_count(q_count), .done_count(done_count),
    .irq_done(irq_done), .err_len(err_len), .err_timeout(err_timeout),
    .queue_busy(queue_busy), .dbg_state(dbg_state)
  );

  // ---------------- driver tasks ----------------
  // One-cycle push; returns at the negedge just after the push edge.
  task automatic push_cmd(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d,
                          input logic [ADDR_W-1:0] l, output logic acc);
    @(negedge clk);
    acc = cmd_ready;
    cmd_valid = 1'b1;
    cmd_src = s;
    cmd_dest = d;
    cmd_len = l;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic pulse_err_clear();
    @(negedge clk);
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (start_transfer !== 1'b0 || irq_done !== 1'b0 || err_len !== 1'b0 || err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset_pulses: start=%b irq=%b elen=%b eto=%b want 0", start_transfer, irq_done, err_len, err_timeout);
    end
    checks++;
    if (src_addr !== '0 || dest_addr !== '0 || transfer_length !== '0) begin
      errors++;
      $display("FAIL reset_addr: src=%h dest=%h len=%h want 0", src_addr, dest_addr, transfer_length);
    end
    checks++;
    if (q_count !== 3'd0 || done_count !== 16'd0 || queue_busy !== 1'b0 || dbg_state !== IDLE) begin
      errors++;
      $display("FAIL reset_counts: q=%0d done=%0d qbusy=%b st=%0d want 0", q_count, done_count, queue_busy, dbg_state);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b want 1", cmd_ready);
    end
  endtask

  task automatic test_single();
    logic acc;
    int irqs = 0;
    int starts = 0;
    push_cmd(32'h1000, 32'h8000, 32'd16, acc);
    checks++;
    if (acc !== 1'b1 || q_count !== 3'd1 || start_transfer !== 1'b0) begin
      errors++;
      $display("FAIL single_push: acc=%b q=%0d start=%b want 1/1/0", acc, q_count, start_transfer);
    end
    @(negedge clk);
    checks++;
    if (start_transfer !== 1'b1 || src_addr !== 32'h1000 || dest_addr !== 32'h8000 || transfer_length !== 32'd16) begin
      errors++;
      $display("FAIL single_start: start=%b src=%h dest=%h len=%0d want 1/1000/8000/16",
               start_transfer, src_addr, dest_addr, transfer_length);
    end
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (start_transfer) starts++;
      if (irq_done) irqs++;
    end
    exp_done = exp_done + 16'd1;
    checks++;
    if (starts != 0 || irqs != 1) begin
      errors++;
      $display("FAIL single_pulses: extra_starts=%0d irqs=%0d want 0/1", starts, irqs);
    end
    checks++;
    if (done_count !== exp_done || queue_busy !== 1'b0 || src_addr !== 32'h1000) begin
      errors++;
      $display("FAIL single_end: done=%0d qbusy=%b src=%h want %0d/0/1000", done_count, queue_busy, src_addr, exp_done);
    end
  endtask

  task automatic test_fill();
    logic acc;
    int starts = 0;
    bit finished = 0;
    @(negedge clk);
    hold_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push_cmd(32'h100 * (i + 1), 32'h4000 + i, 32'd4 * (i + 1), acc);
      if (i < 4) exp_q.push_back(32'h100 * (i + 1));
      if (i == 3) begin
        checks++;
        if (q_count !== 3'd4 || cmd_ready !== 1'b0) begin
          errors++;
          $display("FAIL fill_full: q=%0d ready=%b want 4/0", q_count, cmd_ready);
        end
      end
      if (i == 4) begin
        checks++;
        if (acc !== 1'b0 || q_count !== 3'd4) begin
          errors++;
          $display("FAIL fill_overflow: acc=%b q=%0d want 0/4", acc, q_count);
        end
      end
    end
    hold_busy = 1'b0;
    for (int c = 0; c < 200 && !finished; c++) begin
      @(negedge clk);
      if (start_transfer) begin
        starts++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL fill_order: unexpected start src=%h", src_addr);
        end else if (src_addr !== exp_q[0]) begin
          errors++;
          $display("FAIL fill_order: src=%h want %h", src_addr, exp_q[0]);
          void'(exp_q.pop_front());
        end else begin
          void'(exp_q.pop_front());
        end
      end
      if (exp_q.size() == 0 && !queue_busy) finished = 1;
    end
    exp_done = exp_done + 16'd4;
    checks++;
    if (!finished || starts != 4 || done_count !== exp_done) begin
      errors++;
      $display("FAIL fill_drain: finished=%0d starts=%0d done=%0d want 1/4/%0d", finished, starts, done_count, exp_done);
    end
    exp_q.delete();
  endtask

  task automatic test_bad_len();
    logic acc;
    int starts = 0;
    push_cmd(32'hA000, 32'hB000, 32'd0, acc);
    checks++;
    if (acc !== 1'b1 || err_len !== 1'b1 || q_count !== 3'd0) begin
      errors++;
      $display("FAIL badlen_zero: acc=%b elen=%b q=%0d want 1/1/0", acc, err_len, q_count);
    end
    pulse_err_clear();
    checks++;
    if (err_len !== 1'b0) begin
      errors++;
      $display("FAIL badlen_clear1: elen=%b want 0", err_len);
    end
    // Clear held across the bad push: the new error must win.
    err_clear = 1'b1;
    push_cmd(32'hA004, 32'hB004, 32'd6, acc);
    err_clear = 1'b0;
    checks++;
    if (acc !== 1'b1 || err_len !== 1'b1 || q_count !== 3'd0) begin
      errors++;
      $display("FAIL badlen_six: acc=%b elen=%b q=%0d want 1/1/0", acc, err_len, q_count);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (start_transfer) starts++;
    end
    checks++;
    if (starts != 0 || queue_busy !== 1'b0) begin
      errors++;
      $display("FAIL badlen_nostart: starts=%0d qbusy=%b want 0/0", starts, queue_busy);
    end
    pulse_err_clear();
    checks++;
    if (err_len !== 1'b0) begin
      errors++;
      $display("FAIL badlen_clear2: elen=%b want 0", err_len);
    end
  endtask

  task automatic test_timeout();
    logic acc;
    int k = 0;
    int irqs = 0;
    bit seen = 0;
    @(negedge clk);
    hold_busy = 1'b1;
    ignore_start = 1'b1;
    push_cmd(32'h2000, 32'h2100, 32'd8, acc);
    push_cmd(32'h3000, 32'h3100, 32'd12, acc);
    hold_busy = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (start_transfer) seen = 1;
    end
    checks++;
    if (!seen || src_addr !== 32'h2000) begin
      errors++;
      $display("FAIL timeout_first_start: seen=%0d src=%h want 1/2000", seen, src_addr);
    end
    seen = 0;
    for (int c = 1; c <= 40 && !seen; c++) begin
      @(negedge clk);
      if (irq_done) irqs++;
      if (err_timeout) begin
        seen = 1;
        k = c;
      end
    end
    checks++;
    if (k != TIMEOUT + 1 || irqs != 0) begin
      errors++;
      $display("FAIL timeout_latency: cycles=%0d irqs=%0d want %0d/0", k, irqs, TIMEOUT + 1);
    end
    checks++;
    if (dbg_state !== IDLE || q_count !== 3'd1) begin
      errors++;
      $display("FAIL timeout_idle: st=%0d q=%0d want 0/1", dbg_state, q_count);
    end
    @(negedge clk);
    checks++;
    if (start_transfer !== 1'b1 || src_addr !== 32'h3000) begin
      errors++;
      $display("FAIL timeout_next: start=%b src=%h want 1/3000", start_transfer, src_addr);
    end
    ignore_start = 1'b0;
    irqs = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (irq_done) irqs++;
    end
    exp_done = exp_done + 16'd1;
    checks++;
    if (irqs != 1 || done_count !== exp_done || err_timeout !== 1'b1) begin
      errors++;
      $display("FAIL timeout_recover: irqs=%0d done=%0d eto=%b want 1/%0d/1", irqs, done_count, err_timeout, exp_done);
    end
    pulse_err_clear();
    checks++;
    if (err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_clear: eto=%b want 0", err_timeout);
    end
  endtask

  task automatic test_flush();
    logic acc;
    int irqs = 0;
    int starts = 0;
    bit seen = 0;
    @(negedge clk);
    hold_busy = 1'b1;
    push_cmd(32'h5000, 32'h5100, 32'd4, acc);
    push_cmd(32'h5200, 32'h5300, 32'd8, acc);
    push_cmd(32'h5400, 32'h5500, 32'd12, acc);
    checks++;
    if (q_count !== 3'd3) begin
      errors++;
      $display("FAIL flush_queued: q=%0d want 3", q_count);
    end
    hold_busy = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (dbg_state == WAIT_DONE) seen = 1;
    end
    checks++;
    if (!seen || src_addr !== 32'h5000) begin
      errors++;
      $display("FAIL flush_inflight: seen=%0d src=%h want 1/5000", seen, src_addr);
    end
    // Flush together with a bad-length push: the push is discarded silently.
    flush = 1'b1;
    cmd_valid = 1'b1;
    cmd_len = 32'd5;
    @(negedge clk);
    flush = 1'b0;
    cmd_valid = 1'b0;
    checks++;
    if (q_count !== 3'd0 || err_len !== 1'b0) begin
      errors++;
      $display("FAIL flush_empty: q=%0d elen=%b want 0/0", q_count, err_len);
    end
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (irq_done) irqs++;
      if (start_transfer) starts++;
    end
    exp_done = exp_done + 16'd1;
    checks++;
    if (irqs != 1 || starts != 0 || done_count !== exp_done || queue_busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_complete: irqs=%0d starts=%0d done=%0d qbusy=%b want 1/0/%0d/0",
               irqs, starts, done_count, queue_busy, exp_done);
    end
  endtask

  task automatic test_reset_mid();
    logic acc;
    int irqs = 0;
    bit seen = 0;
    @(negedge clk);
    hold_busy = 1'b1;
    push_cmd(32'h6000, 32'h6100, 32'd16, acc);
    push_cmd(32'h6200, 32'h6300, 32'd20, acc);
    hold_busy = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (dbg_state == WAIT_DONE) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL rstmid_reach: WAIT_DONE not reached, st=%0d", dbg_state);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_done = '0;
    checks++;
    if (start_transfer !== 1'b0 || irq_done !== 1'b0 || src_addr !== '0 || dest_addr !== '0 ||
        transfer_length !== '0 || q_count !== 3'd0 || done_count !== 16'd0 || queue_busy !== 1'b0 ||
        dbg_state !== IDLE) begin
      errors++;
      $display("FAIL rstmid_outputs: start=%b irq=%b src=%h q=%0d done=%0d qbusy=%b st=%0d want all 0",
               start_transfer, irq_done, src_addr, q_count, done_count, queue_busy, dbg_state);
    end
    push_cmd(32'h7000, 32'h9000, 32'd32, acc);
    @(negedge clk);
    checks++;
    if (start_transfer !== 1'b1 || src_addr !== 32'h7000 || dest_addr !== 32'h9000 || transfer_length !== 32'd32) begin
      errors++;
      $display("FAIL rstmid_fresh: start=%b src=%h dest=%h len=%0d want 1/7000/9000/32",
               start_transfer, src_addr, dest_addr, transfer_length);
    end
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (irq_done) irqs++;
    end
    exp_done = exp_done + 16'd1;
    checks++;
    if (irqs != 1 || done_count !== exp_done) begin
      errors++;
      $display("FAIL rstmid_done: irqs=%0d done=%0d want 1/%0d", irqs, done_count, exp_done);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single();
    test_fill();
    test_bad_len();
    test_timeout();
    test_flush();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dma_cmd_queue.md
Name: dma_cmd_queue

Overview:
Descriptor queue and issue sequencer directly upstream of the DMA controller. The CPU pushes {src, dest, length} descriptors with a valid/ready handshake. The block buffers them in a FIFO and issues them one at a time to the DMA's start_transfer/src_addr/dest_addr/transfer_length inputs, tracking dma_busy to detect each completion. It rejects lengths the DMA cannot handle (zero or not a multiple of 4) and raises a done pulse per completed transfer.

Parameters:
DEPTH, 4, descriptor FIFO entries; power of two, >= 2
ADDR_W, 32, width of address and length fields
TIMEOUT, 16, max cycles in WAIT_BUSY before declaring the DMA unresponsive

Ports:
clk  in  1  single clock
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  CPU descriptor valid
cmd_ready  out  1  queue can accept; equals !full
cmd_src  in  ADDR_W  source address
cmd_dest  in  ADDR_W  destination address
cmd_len  in  ADDR_W  length in bytes
flush  in  1  discard all queued (not in-flight) descriptors
err_clear  in  1  clears sticky error flags
start_transfer  out  1  one-cycle start pulse to DMA
src_addr  out  ADDR_W  to DMA; held from ISSUE until the next issue
dest_addr  out  ADDR_W  to DMA; same hold rule
transfer_length  out  ADDR_W  to DMA; same hold rule
dma_busy  in  1  from DMA
q_count  out  clog2(DEPTH)+1  entries currently queued
done_count  out  16  completed transfers; wraps 0xFFFF -> 0
irq_done  out  1  one-cycle pulse per completion
err_len  out  1  sticky: bad-length descriptor dropped
err_timeout  out  1  sticky: DMA never went busy after start
queue_busy  out  1  high when the FSM is not in IDLE or q_count != 0

Behaviour:
- Reset: FIFO emptied; state IDLE. All outputs are 0, including start_transfer, irq_done, errors, counts and address/length outputs. Reset mid-transfer abandons tracking; the DMA is not signalled.
- Push: occurs when cmd_valid && cmd_ready. If cmd_len == 0 or cmd_len[1:0] != 0, the handshake completes but the descriptor is dropped and err_len is set the next cycle. Otherwise the descriptor is written to the FIFO.
- No push bypass when full: cmd_ready is derived from the registered count only. A pop in the same cycle does not raise cmd_ready that cycle.
- Simultaneous push and pop (not full): both take effect and q_count is unchanged.
- FSM states:
  - IDLE: if FIFO non-empty && !dma_busy && !flush, pop the head, load the output registers, and go to ISSUE.
  - ISSUE: start_transfer = 1 for exactly this cycle; go to WAIT_BUSY and clear the timeout counter.
  - WAIT_BUSY: if dma_busy, go to WAIT_DONE. Else increment the counter; at count == TIMEOUT, set err_timeout and go to IDLE. The descriptor is dropped and no irq is raised.
  - WAIT_DONE: if !dma_busy, go to IDLE, pulse irq_done, and increment done_count (all registered, same edge).
- Latency:
  - Push into empty queue with DMA idle: start_transfer is high 2 cycles after the push edge (push edge, IDLE pop edge, ISSUE).
  - Completion: dma_busy falls at cycle M, irq_done is high at M+1, and the next start_transfer is at M+2 if the queue is non-empty.
- flush:
  - Empties the FIFO next edge.
  - A push in the same cycle is discarded; err_len is not set.
  - Does not affect an in-flight transfer or the counters.
- err_clear: clears both sticky flags. If it coincides with a new error event, the error wins.
- Arithmetic: FIFO pointers are clog2(DEPTH) bits with natural wrap. q_count never exceeds DEPTH and never underflows.

Decomposition:
- Shared package dma_pkg holds:
  - the FSM state encoding (IDLE/ISSUE/WAIT_BUSY/WAIT_DONE);
  - the descriptor struct/width (3*ADDR_W);
  - the done_count width constant.
- One sub-module, dma_desc_fifo: a synchronous FIFO with push, pop, flush, full, empty and count. This top level holds the FSM, length check, timeout counter and status.

Test Plan:
- Single descriptor: push src=0x1000, dest=0x8000, len=16 into a behavioural DMA (busy 1 cycle after start, 8 cycles of work). Expect start_transfer exactly one cycle with those values, then irq_done once, done_count=1, queue_busy returns 0.
- Fill: with DMA held busy, push 5 valid descriptors at DEPTH=4. Expect cmd_ready=0 after the 4th and q_count=4. On release, the 4 transfers issue in FIFO order and done_count=4.
- Bad length: push len=0, then len=6. Expect both handshakes to complete, q_count to stay 0, err_len=1 and no start_transfer. After err_clear, err_len=0.
- Timeout: the DMA model ignores start. Expect err_timeout=1 exactly TIMEOUT+1 cycles after the start pulse, FSM back in IDLE, and the next queued descriptor issued.
- Flush: queue 3, flush during the first transfer. Expect q_count=0 the next cycle, the in-flight transfer to complete with irq_done, and no further starts.
- Reset mid-WAIT_DONE: assert reset for 1 cycle. Expect all outputs 0 the next cycle and q_count=0. A fresh push then issues normally.
